// File: rtl/sequential_fp_divider.sv
// Iterative single-precision divider (a / b), restoring radix-2, truncating.
// Define FPDIV_NAN_EN to return quiet NaN for 0/0, inf/inf and NaN operands.
module sequential_fp_divider #(
    parameter int EXP_BIAS = 127,
    parameter int QBITS    = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CNT_W = $clog2(QBITS + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t             state, state_nxt;
    logic               sign;
    logic [7:0]         exp_a, exp_b;
    logic               man_a_nz, man_b_nz;
    logic [24:0]        rem;
    logic [23:0]        divisor;
    logic [QBITS-1:0]   quo;
    logic [CNT_W-1:0]   cnt;

    logic               q_bit;
    logic [24:0]        rem_sub;
    logic signed [9:0]  exp_q;
    logic [22:0]        mant_q;
    logic [31:0]        norm_val;

    // Clamp a biased exponent to the representable range: no denormals.
    function automatic logic [31:0] sat_pack(input logic s, input logic signed [9:0] e,
                                             input logic [22:0] m);
        if (e >= 10'sd255)
            sat_pack = {s, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            sat_pack = {s, 31'h0};
        else
            sat_pack = {s, e[7:0], m};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DIVIDE;
            DIVIDE:  if (cnt == CNT_W'(QBITS - 1)) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign q_bit   = (rem >= {1'b0, divisor});
    assign rem_sub = q_bit ? (rem - {1'b0, divisor}) : rem;

    always_comb begin
        exp_q  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + $signed(10'(EXP_BIAS));
        mant_q = quo[QBITS-2 -: 23];
        if (!quo[QBITS-1]) begin
            exp_q  = exp_q - 10'sd1;
            mant_q = quo[QBITS-3 -: 23];
        end

        norm_val = sat_pack(sign, exp_q, mant_q);
        if (exp_b == 8'hFF) norm_val = {sign, 31'h0};
        if (exp_b == 8'h00) norm_val = {sign, 8'hFF, 23'h0};
        if (exp_a == 8'hFF) norm_val = {sign, 8'hFF, 23'h0};
        if (exp_a == 8'h00) norm_val = {sign, 31'h0};
`ifdef FPDIV_NAN_EN
        if ((exp_a == 8'h00 && exp_b == 8'h00) || (exp_a == 8'hFF && exp_b == 8'hFF) ||
            (exp_a == 8'hFF && man_a_nz) || (exp_b == 8'hFF && man_b_nz))
            norm_val = 32'h7FC0_0000;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign     <= 1'b0;
            exp_a    <= 8'h0;
            exp_b    <= 8'h0;
            man_a_nz <= 1'b0;
            man_b_nz <= 1'b0;
            rem      <= 25'h0;
            divisor  <= 24'h0;
            quo      <= '0;
            cnt      <= '0;
            result   <= 32'h0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sign     <= a[31] ^ b[31];
                    exp_a    <= a[30:23];
                    exp_b    <= b[30:23];
                    man_a_nz <= |a[22:0];
                    man_b_nz <= |b[22:0];
                    rem      <= {2'b01, a[22:0]};
                    divisor  <= {1'b1, b[22:0]};
                    quo      <= '0;
                    cnt      <= '0;
                end
                // One quotient bit per cycle, MSB first; remainder stays below 2*divisor.
                DIVIDE: begin
                    rem <= rem_sub << 1;
                    quo <= {quo[QBITS-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                NORM:    result <= norm_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_fp_divider.sv
// Directed self-checking bench for sequential_fp_divider (default and FPDIV_NAN_EN builds).
module tb_sequential_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sequential_fp_divider #(.EXP_BIAS(127), .QBITS(25)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the edge where done rose (or after the bound).
    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic issue(input logic [31:0] aa, input logic [31:0] bb, output int k);
        @(negedge clk);
        a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] exp);
        int k;
        issue(aa, bb, k);
        wait_done();
        check({tag, "_lat"}, 32'(cyc - k), 32'd26);
        check(tag, result, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int k, extra, gap;
        rst = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        @(negedge clk) rst = 1'b0;

        // 6.0 / 2.0: latency and busy window
        issue(32'h40C00000, 32'h40000000, k);
        check("busy_after_start", {31'h0, busy}, 32'h1);
        wait_done();
        check("lat_6_2", 32'(cyc - k), 32'd26);
        check("res_6_2", result, 32'h40400000);
        check("busy_at_done", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        check("done_one_cycle", {31'h0, done}, 32'h0);
        check("busy_end", {31'h0, busy}, 32'h0);

        // 1.0 / 3.0 with a stray start while busy
        issue(32'h3F800000, 32'h40400000, k);
        repeat (5) @(posedge clk);
        @(negedge clk);
        a = 32'h40C00000; b = 32'h3F800000; start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();
        check("lat_1_3", 32'(cyc - k), 32'd26);
        check("res_1_3", result, 32'h3EAAAAAA);
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("no_extra_done", 32'(extra), 32'd0);
        check("result_hold", result, 32'h3EAAAAAA);

        // Asynchronous reset ten cycles into DIVIDE
        issue(32'h40C00000, 32'h40000000, k);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_result", result, 32'h0);
        @(negedge clk) rst = 1'b0;
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("midrst_no_done", 32'(extra), 32'd0);

        // Special cases and range limits
        run_op("div_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000);
`ifdef FPDIV_NAN_EN
        run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000);
        run_op("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000);
        run_op("nan_operand", 32'h7F800001, 32'h3F800000, 32'h7FC00000);
`else
        run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h00000000);
        run_op("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7F800000);
        run_op("nan_operand", 32'h7F800001, 32'h3F800000, 32'h7F800000);
`endif
        run_op("inf_divisor", 32'hC0000000, 32'h7F800000, 32'h80000000);
        run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000);
        run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000);

        // Back-to-back: start held through DONE (ignored) into the first IDLE cycle
        issue(32'h40C00000, 32'h40000000, k);
        wait_done();
        check("b2b_first", result, 32'h40400000);
        a = 32'h41100000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_done_fall", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        while (done !== 1'b1 && gap < 100) begin
            @(posedge clk); #1;
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'd27);
        check("b2b_second", result, 32'h40400000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
